// File: rtl/req_issuer_pkg.sv
// Shared types and default parameters for the req/gnt request issuer.
// Imported by the issuer top and its command FIFO.
package req_issuer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int unsigned DEF_DATA_W  = 8;
   localparam int unsigned DEF_DEPTH   = 4;
   localparam int unsigned DEF_TIMEOUT = 8;

endpackage

// File: rtl/req_cmd_fifo.sv
// Command FIFO for the request issuer: registered count, natural pointer wrap.
// Pushes while full and pops while empty are ignored.
module req_cmd_fifo
   import req_issuer_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic do_push;
   logic do_pop;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: head is only consumed while count is non-zero.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/req_issuer.sv
// Issues one registered req per queued command, held until gnt or timeout,
// with a guaranteed one-cycle low gap between consecutive requests.
module req_issuer
   import req_issuer_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              cmd_ready,
   output logic              req,
   output logic [DATA_W-1:0] req_data,
   input  logic              gnt,
   output logic              done,
   output logic              timeout_err,
   output logic              busy
);

   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
   localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_t state_q, state_d;

   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              req_q, req_d;
   logic [DATA_W-1:0] req_data_q, req_data_d;
   logic              done_q, done_d;
   logic              timeout_err_q, timeout_err_d;

   logic              fifo_push;
   logic              fifo_pop;
   logic [DATA_W-1:0] fifo_head;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;

   assign cmd_ready = !fifo_full;
   assign fifo_push = cmd_valid && cmd_ready;

   req_cmd_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (fifo_push),
      .push_data (cmd_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      req_d         = 1'b0;
      req_data_d    = '0;
      done_d        = 1'b0;
      timeout_err_d = 1'b0;
      fifo_pop      = 1'b0;

      unique case (state_q)
         IDLE, GAP: begin
            // Registered count: a push on this edge is seen next cycle.
            if (!fifo_empty) begin
               state_d    = REQ;
               wait_cnt_d = '0;
               req_d      = 1'b1;
               req_data_d = fifo_head;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (gnt) begin
               fifo_pop = 1'b1;
               done_d   = 1'b1;
               state_d  = GAP;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               if (wait_cnt_q == WAIT_LAST) begin
                  fifo_pop      = 1'b1;
                  timeout_err_d = 1'b1;
                  state_d       = GAP;
               end else begin
                  req_d      = 1'b1;
                  req_data_d = req_data_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         wait_cnt_q    <= '0;
         req_q         <= 1'b0;
         req_data_q    <= '0;
         done_q        <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         req_q         <= req_d;
         req_data_q    <= req_data_d;
         done_q        <= done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign req         = req_q;
   assign req_data    = req_data_q;
   assign done        = done_q;
   assign timeout_err = timeout_err_q;
   assign busy        = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_req_issuer.sv
// Bench for req_issuer: table of single-command grant/timeout cases,
// plus back-to-back, full-FIFO stall, idle-gnt and async-reset sequences.
module tb_req_issuer;

   localparam int DATA_W  = 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 8;

   logic              clk;
   logic              reset_n;
   logic              cmd_valid;
   logic [DATA_W-1:0] cmd_data;
   logic              cmd_ready;
   logic              req;
   logic [DATA_W-1:0] req_data;
   logic              gnt;
   logic              done;
   logic              timeout_err;
   logic              busy;

   req_issuer #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cmd_valid   (cmd_valid),
      .cmd_data    (cmd_data),
      .cmd_ready   (cmd_ready),
      .req         (req),
      .req_data    (req_data),
      .gnt         (gnt),
      .done        (done),
      .timeout_err (timeout_err),
      .busy        (busy)
   );

   typedef struct {
      logic [7:0] data;
      int         gnt_at;
      int         exp_len;
      logic       exp_done;
   } item_t;

   item_t sb[$];

   int   passes = 0;
   int   total  = 0;
   logic gnt_idle = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic item_t mk(input logic [7:0] d, input int g);
      item_t it;
      it.data     = d;
      it.gnt_at   = g;
      it.exp_done = (g >= 1 && g <= TIMEOUT);
      it.exp_len  = it.exp_done ? g : TIMEOUT;
      return it;
   endfunction

   // Monitor + gnt responder; the responder grants on req cycle gnt_at
   // of the command at the scoreboard head.
   initial begin
      int   len;
      logic prev_req;
      item_t it;
      len      = 0;
      prev_req = 1'b0;
      gnt      = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            len      = 0;
            prev_req = 1'b0;
            gnt      = 1'b0;
         end else begin
            if (done || timeout_err) begin
               chk("pulse_one_hot", done & timeout_err, 0);
               chk("pulse_after_req", prev_req, 1);
               if (sb.size() == 0) begin
                  total++;
                  $display("FAIL sb_unexpected_pulse: got pulse expected none");
               end else begin
                  it = sb.pop_front();
                  chk("sb_kind_done", done, it.exp_done);
                  chk("sb_req_len", len, it.exp_len);
               end
            end
            if (req) begin
               len = prev_req ? len + 1 : 1;
               if (sb.size() == 0) begin
                  total++;
                  $display("FAIL sb_unexpected_req: got req expected none");
               end else begin
                  chk("sb_req_data", req_data, sb[0].data);
               end
            end
            gnt = req ? (sb.size() > 0 && sb[0].gnt_at == len) : gnt_idle;
            prev_req = req;
         end
      end
   end

   task automatic push_cmd(input item_t it, output int waited,
                           output logic pulse);
      cmd_valid = 1'b1;
      cmd_data  = it.data;
      sb.push_back(it);
      waited = 0;
      while (!cmd_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      pulse = timeout_err;
      if (!cmd_ready) begin
         total++;
         $display("FAIL push_wait: got ready 0 expected 1 within 100");
      end
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(name, busy, 0);
   endtask

   item_t vec[6];

   initial begin
      int   w;
      int   n;
      logic p;
      logic [5:0] rp;
      logic [5:0] dp;
      int   seen;

      vec[0] = '{8'h5A, 2, 2, 1'b1};
      vec[1] = '{8'hC3, 0, 8, 1'b0};
      vec[2] = '{8'h11, 8, 8, 1'b1};
      vec[3] = '{8'h22, 1, 1, 1'b1};
      vec[4] = '{8'hFF, 7, 7, 1'b1};
      vec[5] = '{8'h80, 9, 8, 1'b0};

      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_data  = '0;
      repeat (3) @(negedge clk);
      chk("rst_req", req, 0);
      chk("rst_req_data", req_data, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      reset_n = 1'b1;
      @(negedge clk);

      // Single-command table: latency, req length, outcome, busy drop.
      for (int i = 0; i < 6; i++) begin
         push_cmd(vec[i], w, p);
         chk("vec_lat_low", req, 0);
         chk("vec_busy", busy, 1);
         @(negedge clk);
         chk("vec_lat_high", req, 1);
         chk("vec_req_data", req_data, vec[i].data);
         n = 0;
         while (!(done || timeout_err) && n < 40) begin
            @(negedge clk);
            n++;
         end
         chk("vec_len", n, vec[i].exp_len);
         chk("vec_done", done, vec[i].exp_done);
         chk("vec_timeout", timeout_err, !vec[i].exp_done);
         chk("vec_req_fell", req, 0);
         @(negedge clk);
         chk("vec_pulse_1cyc", done | timeout_err, 0);
         chk("vec_busy_fall", busy, 0);
      end

      // Back-to-back, grant on first req cycle: 1-wide pulses, 1-cycle gaps.
      push_cmd(mk(8'h01, 1), w, p);
      push_cmd(mk(8'h02, 1), w, p);
      push_cmd(mk(8'h03, 1), w, p);
      for (int i = 5; i >= 0; i--) begin
         rp[i] = req;
         dp[i] = done;
         @(negedge clk);
      end
      chk("b2b_req_pattern", rp, 6'b010100);
      chk("b2b_done_pattern", dp, 6'b101010);
      chk("b2b_idle", busy, 0);

      // Full FIFO with gnt never: fifth command waits for first timeout.
      for (int i = 0; i < 4; i++) push_cmd(mk(8'hA0 + 8'(i), 0), w, p);
      chk("full_ready_low", cmd_ready, 0);
      push_cmd(mk(8'hA4, 0), w, p);
      chk("full_held_cycles", w, TIMEOUT - 2);
      chk("full_ready_on_timeout", p, 1);
      wait_idle("full_drain");
      chk("full_sb_empty", sb.size(), 0);

      // gnt outside REQ is ignored, also during the latency and gap cycles.
      gnt_idle = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         seen += int'(req) + int'(done) + int'(timeout_err) + int'(busy);
      end
      chk("idle_gnt_ignored", seen, 0);
      push_cmd(mk(8'h3C, 3), w, p);
      n = 0;
      while (!(done || timeout_err) && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("idle_gnt_done", done, 1);
      chk("idle_gnt_len", n, 4);
      gnt_idle = 1'b0;
      wait_idle("idle_gnt_drain");

      // Async reset mid-REQ with two commands queued behind.
      push_cmd(mk(8'hD1, 0), w, p);
      push_cmd(mk(8'hD2, 0), w, p);
      push_cmd(mk(8'hD3, 0), w, p);
      chk("rst_mid_req_high", req, 1);
      #2;
      reset_n = 1'b0;
      sb.delete();
      #1;
      chk("rst_mid_req_drop", req, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ready", cmd_ready, 1);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         seen += int'(req) + int'(done) + int'(timeout_err) + int'(busy);
         seen += int'(!cmd_ready);
      end
      chk("rst_mid_quiet", seen, 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
